// File: rtl/window_3x3_gen_if.sv
// Pixel-stream input and window output bundle for window_3x3_gen.
// Optional WIN_COORD_EN adds the win_x/win_y centre coordinate signals.
interface window_3x3_gen_if #(
  parameter int DW = 8
);
  logic            pix_valid;
  logic            pix_sof;
  logic [DW-1:0]   pix_data;
  logic            win_valid;
  logic [9*DW-1:0] win_data;
  logic            frame_done;
`ifdef WIN_COORD_EN
  logic [15:0]     win_x;
  logic [15:0]     win_y;

  modport master (
    output pix_valid, pix_sof, pix_data,
    input  win_valid, win_data, frame_done, win_x, win_y
  );
  modport slave (
    input  pix_valid, pix_sof, pix_data,
    output win_valid, win_data, frame_done, win_x, win_y
  );
`else
  modport master (
    output pix_valid, pix_sof, pix_data,
    input  win_valid, win_data, frame_done
  );
  modport slave (
    input  pix_valid, pix_sof, pix_data,
    output win_valid, win_data, frame_done
  );
`endif
endinterface

// File: rtl/window_3x3_gen.sv
// Sliding 3x3 window generator over a raster pixel stream using two line buffers.
// Define WIN_COORD_EN to add the win_x/win_y window-centre outputs.
module window_3x3_gen #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int DW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  window_3x3_gen_if.slave   bus
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  state_t state, state_nxt;

  logic [XW-1:0] x, cur_x;
  logic [YW-1:0] y, cur_y;
  logic          in_frame, proc, emit, x_last, y_last;

  logic [DW-1:0] lb0 [IMG_W];
  logic [DW-1:0] lb1 [IMG_W];
  logic [DW-1:0] lb0_rd, lb1_rd;

  // hist[r][0]/[1] are the middle and right columns of the most recent window
  logic [2:0][1:0][DW-1:0] hist;
  logic [2:0][DW-1:0]      col_new;
  logic [9*DW-1:0]         win_flat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (bus.pix_valid && bus.pix_sof) state_nxt = FILL;
      FILL: begin
        if (bus.pix_valid && bus.pix_sof)                    state_nxt = FILL;
        else if (bus.pix_valid && x == '0 && y == YW'(2))    state_nxt = STREAM;
      end
      STREAM: begin
        if (bus.pix_valid && bus.pix_sof)                    state_nxt = FILL;
        else if (bus.pix_valid && x_last && y_last)          state_nxt = DONE;
      end
    endcase
  end

  always_comb begin
    in_frame = (state == FILL) || (state == STREAM);
    proc     = bus.pix_valid && (bus.pix_sof || in_frame);
  end

  // A sof pixel is always (0,0), so the counters are overridden combinationally.
  always_comb begin
    cur_x   = bus.pix_sof ? '0 : x;
    cur_y   = bus.pix_sof ? '0 : y;
    x_last  = (cur_x == X_LAST);
    y_last  = (cur_y == Y_LAST);
    emit    = proc && (cur_x >= XW'(2)) && (cur_y >= YW'(2));
    lb0_rd  = lb0[cur_x];
    lb1_rd  = lb1[cur_x];
    col_new = {bus.pix_data, lb0_rd, lb1_rd};
    win_flat = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      win_flat[DW*(3*r)   +: DW] = hist[r][0];
      win_flat[DW*(3*r+1) +: DW] = hist[r][1];
      win_flat[DW*(3*r+2) +: DW] = col_new[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (proc) begin
      x <= x_last ? '0 : cur_x + 1'b1;
      if (x_last) y <= y_last ? '0 : cur_y + 1'b1;
      else        y <= cur_y;
    end
  end

  always_ff @(posedge clk) begin
    if (proc) begin
      lb1[cur_x] <= lb0_rd;
      lb0[cur_x] <= bus.pix_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
    end else if (proc) begin
      for (int unsigned r = 0; r < 3; r++) begin
        hist[r][0] <= hist[r][1];
        hist[r][1] <= col_new[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.win_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.win_data   <= '0;
    end else begin
      bus.win_valid  <= emit;
      bus.frame_done <= emit && x_last && y_last;
      if (emit) bus.win_data <= win_flat;
    end
  end

`ifdef WIN_COORD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.win_x <= '0;
      bus.win_y <= '0;
    end else if (emit) begin
      bus.win_x <= 16'(cur_x) - 16'd1;
      bus.win_y <= 16'(cur_y) - 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 4x4 image with pixel(x,y) = 16*y+x.
module tb_window_3x3_gen;
  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_3x3_gen_if #(.DW(8)) bus();
  window_3x3_gen #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [71:0] data;
    logic        fd;
    int          cyc;
    logic [15:0] wx;
    logic [15:0] wy;
  } rec_t;

  rec_t got[$];
  int   fd_count = 0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   acc_cyc[16];
  int   gap_tab[16] = '{0, 2, 0, 3, 1, 0, 0, 2, 3, 0, 1, 0, 2, 1, 3, 0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.win_valid) begin
        rec_t r;
        r.data = bus.win_data;
        r.fd   = bus.frame_done;
        r.cyc  = cyc;
`ifdef WIN_COORD_EN
        r.wx   = bus.win_x;
        r.wy   = bus.win_y;
`else
        r.wx   = '0;
        r.wy   = '0;
`endif
        got.push_back(r);
      end
      if (bus.frame_done) fd_count <= fd_count + 1;
    end
  end

  function automatic logic [71:0] exp_win(input int cx, input int cy);
    logic [71:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[8*(3*r+c) +: 8] = 8'(16*(cy-1+r) + (cx-1+c));
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
    end
  endtask

  task automatic put(input bit sof, input int x, input int y, input int gap);
    idle(gap);
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_sof   = sof;
    bus.pix_data  = 8'(16*y + x);
    acc_cyc[(4*y + x) % 16] = cyc;
  endtask

  task automatic send_frame(input bit use_gaps);
    for (int i = 0; i < 16; i++) put(i == 0, i % 4, i / 4, use_gaps ? gap_tab[i] : 0);
    idle(3);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_data  = '0;
    repeat (3) @(negedge clk);
    tests++; if (bus.win_valid !== 1'b0) begin fails++; $display("FAIL reset_win_valid: got %b expected 0", bus.win_valid); end
    tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
    tests++; if (bus.win_data !== 72'h0) begin fails++; $display("FAIL reset_win_data: got %h expected 0", bus.win_data); end
`ifdef WIN_COORD_EN
    tests++; if (bus.win_x !== 16'd0 || bus.win_y !== 16'd0) begin fails++; $display("FAIL reset_coord: got %0d,%0d expected 0,0", bus.win_x, bus.win_y); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_stream;
    int f0;
    got.delete();
    f0 = fd_count;
    send_frame(1'b0);
    tests++; if (got.size() !== 4) begin fails++; $display("FAIL stream_count: got %0d expected 4", got.size()); end
    tests++; if (fd_count - f0 !== 1) begin fails++; $display("FAIL stream_frame_done_count: got %0d expected 1", fd_count - f0); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      int cx, cy, p;
      cx = 1 + k % 2; cy = 1 + k / 2; p = 4*(cy+1) + cx + 1;
      tests++; if (got[k].data !== exp_win(cx, cy)) begin fails++; $display("FAIL stream_data[%0d]: got %h expected %h", k, got[k].data, exp_win(cx, cy)); end
      tests++; if (got[k].cyc !== acc_cyc[p] + 1) begin fails++; $display("FAIL stream_timing[%0d]: got cycle %0d expected %0d", k, got[k].cyc, acc_cyc[p] + 1); end
      tests++; if (got[k].fd !== (k == 3)) begin fails++; $display("FAIL stream_fd_align[%0d]: got %b expected %b", k, got[k].fd, k == 3); end
`ifdef WIN_COORD_EN
      tests++; if (got[k].wx !== 16'(cx) || got[k].wy !== 16'(cy)) begin fails++; $display("FAIL stream_coord[%0d]: got %0d,%0d expected %0d,%0d", k, got[k].wx, got[k].wy, cx, cy); end
`endif
    end
  endtask

  task automatic test_gaps;
    int f0;
    got.delete();
    f0 = fd_count;
    send_frame(1'b1);
    tests++; if (got.size() !== 4) begin fails++; $display("FAIL gaps_count: got %0d expected 4", got.size()); end
    tests++; if (fd_count - f0 !== 1) begin fails++; $display("FAIL gaps_frame_done_count: got %0d expected 1", fd_count - f0); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      int cx, cy, p;
      cx = 1 + k % 2; cy = 1 + k / 2; p = 4*(cy+1) + cx + 1;
      tests++; if (got[k].data !== exp_win(cx, cy)) begin fails++; $display("FAIL gaps_data[%0d]: got %h expected %h", k, got[k].data, exp_win(cx, cy)); end
      tests++; if (got[k].cyc !== acc_cyc[p] + 1) begin fails++; $display("FAIL gaps_timing[%0d]: got cycle %0d expected %0d", k, got[k].cyc, acc_cyc[p] + 1); end
    end
  endtask

  task automatic test_restart;
    int f0;
    got.delete();
    f0 = fd_count;
    for (int i = 0; i < 13; i++) put(i == 0, i % 4, i / 4, 0);
    idle(2);
    #1;
    tests++; if (got.size() !== 2) begin fails++; $display("FAIL restart_partial_count: got %0d expected 2", got.size()); end
    for (int k = 0; k < got.size() && k < 2; k++) begin
      tests++; if (got[k].data !== exp_win(1 + k, 1)) begin fails++; $display("FAIL restart_partial_data[%0d]: got %h expected %h", k, got[k].data, exp_win(1 + k, 1)); end
    end
    got.delete();
    send_frame(1'b0);
    tests++; if (fd_count - f0 !== 1) begin fails++; $display("FAIL restart_frame_done_count: got %0d expected 1", fd_count - f0); end
    tests++; if (got.size() !== 4) begin fails++; $display("FAIL restart_count: got %0d expected 4", got.size()); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      tests++; if (got[k].data !== exp_win(1 + k % 2, 1 + k / 2)) begin fails++; $display("FAIL restart_data[%0d]: got %h expected %h", k, got[k].data, exp_win(1 + k % 2, 1 + k / 2)); end
      tests++; if (got[k].fd !== (k == 3)) begin fails++; $display("FAIL restart_fd_align[%0d]: got %b expected %b", k, got[k].fd, k == 3); end
    end
  endtask

  task automatic test_reset_mid;
    int f0;
    got.delete();
    f0 = fd_count;
    for (int i = 0; i < 11; i++) put(i == 0, i % 4, i / 4, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    @(negedge clk);
    tests++; if (bus.win_valid !== 1'b0) begin fails++; $display("FAIL midreset_win_valid: got %b expected 0", bus.win_valid); end
    tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL midreset_frame_done: got %b expected 0", bus.frame_done); end
    tests++; if (bus.win_data !== 72'h0) begin fails++; $display("FAIL midreset_win_data: got %h expected 0", bus.win_data); end
    rst = 1'b0;
    for (int i = 11; i < 16; i++) put(1'b0, i % 4, i / 4, 0);
    idle(3);
    #1;
    tests++; if (got.size() !== 0) begin fails++; $display("FAIL midreset_drop_count: got %0d expected 0", got.size()); end
    send_frame(1'b0);
    tests++; if (got.size() !== 4) begin fails++; $display("FAIL midreset_frame_count: got %0d expected 4", got.size()); end
    tests++; if (fd_count - f0 !== 1) begin fails++; $display("FAIL midreset_frame_done_count: got %0d expected 1", fd_count - f0); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      tests++; if (got[k].data !== exp_win(1 + k % 2, 1 + k / 2)) begin fails++; $display("FAIL midreset_data[%0d]: got %h expected %h", k, got[k].data, exp_win(1 + k % 2, 1 + k / 2)); end
    end
  endtask

  task automatic test_after_done;
    int f0;
    got.delete();
    f0 = fd_count;
    for (int i = 0; i < 5; i++) put(1'b0, i % 4, 2 + i / 4, 0);
    idle(3);
    #1;
    tests++; if (got.size() !== 0) begin fails++; $display("FAIL after_done_windows: got %0d expected 0", got.size()); end
    tests++; if (fd_count - f0 !== 0) begin fails++; $display("FAIL after_done_frame_done: got %0d expected 0", fd_count - f0); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_after_done();
    test_gaps();
    test_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
